// File: rtl/noc_vc_credit_fc.sv
// Per-VC credit flow control with a one-deep registered output stage.
// Optional pause generator (IDLE/SEND/HOLD) is built when NOC_FC_PAUSE_EN is defined.
module noc_vc_credit_fc #(
    parameter int          VC_NUM       = 4,
    parameter int          DATA_WIDTH   = 64,
    parameter int          CREDIT_WIDTH = 5,
    parameter int          MAX_CREDIT   = 16,
    parameter logic [15:0] STALL_LIMIT  = 16'd255,
    parameter int          LOW_WM       = 2,
    localparam int         VC_W         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [VC_W-1:0]                in_vc,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [VC_W-1:0]                out_vc,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic                           out_ready,
    input  logic [VC_NUM-1:0]              credit_ret,
    output logic [VC_NUM*CREDIT_WIDTH-1:0] credit_cnt,
    output logic [VC_NUM-1:0]              credit_err,
    output logic                           stall_err,
    input  logic                           err_clr,
    output logic                           pause_req_o,
    output logic                           pause_active,
    input  logic [15:0]                    pause_quanta
);

    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(MAX_CREDIT);
    localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = CREDIT_WIDTH'(1);

    logic [VC_NUM-1:0][CREDIT_WIDTH-1:0] cred_q, cred_d;
    logic [VC_NUM-1:0]                   cerr_q, cerr_d, cerr_set;
    logic [VC_NUM-1:0]                   take;
    logic                                out_valid_q, out_valid_d;
    logic [VC_W-1:0]                     out_vc_q, out_vc_d;
    logic [DATA_WIDTH-1:0]               out_data_q, out_data_d;
    logic [15:0]                         stv_q, stv_d;
    logic                                stall_q, stall_d;
    logic                                vc_ok, cred_zero, accept, starving, pause_block;

    // Decode the requested VC: legality and whether it has run dry.
    always_comb begin
        vc_ok     = 1'b0;
        cred_zero = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            if (in_vc == VC_W'(v)) begin
                vc_ok     = 1'b1;
                cred_zero = (cred_q[v] == '0);
            end
        end
    end

    always_comb begin
        in_ready = vc_ok && !cred_zero && (!out_valid_q || out_ready) && !pause_block;
        accept   = in_valid && in_ready;
        take     = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            take[v] = accept && (in_vc == VC_W'(v));
        end
    end

    // A consume and a return on the same VC cancel; a lone return at the ceiling is an overflow.
    always_comb begin
        cred_d   = cred_q;
        cerr_set = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (take[v] && !credit_ret[v]) begin
                cred_d[v] = cred_q[v] - CRED_ONE;
            end else if (credit_ret[v] && !take[v]) begin
                if (cred_q[v] >= CRED_MAX) begin
                    cerr_set[v] = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + CRED_ONE;
                end
            end
        end
        cerr_d = (cerr_q & ~{VC_NUM{err_clr}}) | cerr_set;
    end

    always_comb begin
        starving = in_valid && vc_ok && cred_zero;
        stv_d    = stv_q;
        if (accept || !in_valid) begin
            stv_d = '0;
        end else if (starving && (stv_q < STALL_LIMIT)) begin
            stv_d = stv_q + 16'd1;
        end
        stall_d = (stall_q && !err_clr) || (starving && (stv_d >= STALL_LIMIT));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_vc_d    = out_vc_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_vc_d    = in_vc;
            out_data_d  = in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred_q      <= {VC_NUM{CRED_MAX}};
            cerr_q      <= '0;
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_data_q  <= '0;
            stv_q       <= '0;
            stall_q     <= 1'b0;
        end else begin
            cred_q      <= cred_d;
            cerr_q      <= cerr_d;
            out_valid_q <= out_valid_d;
            out_vc_q    <= out_vc_d;
            out_data_q  <= out_data_d;
            stv_q       <= stv_d;
            stall_q     <= stall_d;
        end
    end

    assign credit_cnt = cred_q;
    assign credit_err = cerr_q;
    assign stall_err  = stall_q;
    assign out_valid  = out_valid_q;
    assign out_vc     = out_vc_q;
    assign out_data   = out_data_q;

`ifdef NOC_FC_PAUSE_EN
    typedef enum logic [1:0] {P_IDLE, P_SEND, P_HOLD} pstate_e;

    pstate_e     pst_q, pst_d;
    logic [15:0] pq_q, pq_d;
    logic        low_hit;

    always_comb begin
        low_hit = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (int'(cred_q[v]) <= LOW_WM) begin
                low_hit = 1'b1;
            end
        end
    end

    // HOLD runs for max(1, pause_quanta) cycles: leave once the loaded count is at or below one.
    always_comb begin
        pst_d        = pst_q;
        pq_d         = pq_q;
        pause_req_o  = 1'b0;
        pause_active = 1'b0;
        case (pst_q)
            P_IDLE: begin
                if (low_hit) begin
                    pst_d = P_SEND;
                end
            end
            P_SEND: begin
                pause_req_o = 1'b1;
                pst_d       = P_HOLD;
                pq_d        = pause_quanta;
            end
            P_HOLD: begin
                pause_active = 1'b1;
                if (pq_q <= 16'd1) begin
                    pst_d = P_IDLE;
                    pq_d  = '0;
                end else begin
                    pq_d = pq_q - 16'd1;
                end
            end
            default: begin
                pst_d = P_IDLE;
                pq_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst_q <= P_IDLE;
            pq_q  <= '0;
        end else begin
            pst_q <= pst_d;
            pq_q  <= pq_d;
        end
    end

    assign pause_block = pause_active;
`else
    logic unused_pause;

    assign pause_req_o  = 1'b0;
    assign pause_active = 1'b0;
    assign pause_block  = 1'b0;
    assign unused_pause = ^{pause_quanta, LOW_WM};
`endif

endmodule

// File: tb/tb_noc_vc_credit_fc.sv
// Directed and randomized bench for noc_vc_credit_fc against a cycle-level credit model.
module tb_noc_vc_credit_fc;

    localparam int VC_NUM = 4;
    localparam int DW     = 64;
    localparam int CW     = 5;
    localparam int MAXC   = 16;
    localparam int LIM    = 255;
    localparam int LOWWM  = 2;
    localparam int VC_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic [VC_W-1:0]      in_vc = '0;
    logic [DW-1:0]        in_data = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [VC_W-1:0]      out_vc;
    logic [DW-1:0]        out_data;
    logic                 out_ready = 1'b1;
    logic [VC_NUM-1:0]    credit_ret = '0;
    logic [VC_NUM*CW-1:0] credit_cnt;
    logic [VC_NUM-1:0]    credit_err;
    logic                 stall_err;
    logic                 err_clr = 1'b0;
    logic                 pause_req_o;
    logic                 pause_active;
    logic [15:0]          pause_quanta = 16'd10;

    noc_vc_credit_fc #(
        .VC_NUM(VC_NUM), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .MAX_CREDIT(MAXC),
        .STALL_LIMIT(16'd255), .LOW_WM(LOWWM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_vc(out_vc), .out_data(out_data), .out_ready(out_ready),
        .credit_ret(credit_ret), .credit_cnt(credit_cnt), .credit_err(credit_err),
        .stall_err(stall_err), .err_clr(err_clr),
        .pause_req_o(pause_req_o), .pause_active(pause_active), .pause_quanta(pause_quanta)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_cred [VC_NUM];
    bit          m_cerr [VC_NUM];
    int          m_starve;
    bit          m_stall;
    bit          m_ov;
    int          m_ovc;
    logic [63:0] m_od;
    int          m_phase;   // 0 idle, 1 pause request, 2 pause window
    int          m_rem;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            m_cred[v] = MAXC;
            m_cerr[v] = 1'b0;
        end
        m_starve = 0;
        m_stall  = 1'b0;
        m_ov     = 1'b0;
        m_ovc    = 0;
        m_od     = '0;
        m_phase  = 0;
        m_rem    = 0;
    endtask

    function automatic bit model_ready();
        if (int'(in_vc) >= VC_NUM) return 1'b0;
        return (!m_ov || out_ready) && (m_cred[int'(in_vc)] != 0) && (m_phase != 2);
    endfunction

    task automatic model_update(input bit acc);
        int  oc [VC_NUM];
        int  c;
        bit  starving;
        bit  vc_ok;
        for (int v = 0; v < VC_NUM; v++) oc[v] = m_cred[v];
        vc_ok = int'(in_vc) < VC_NUM;
`ifdef NOC_FC_PAUSE_EN
        if (m_phase == 0) begin
            for (int v = 0; v < VC_NUM; v++) if (oc[v] <= LOWWM) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_rem   = int'(pause_quanta);
        end else begin
            if (m_rem <= 1) m_phase = 0;
            else m_rem = m_rem - 1;
        end
`endif
        if (err_clr) for (int v = 0; v < VC_NUM; v++) m_cerr[v] = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            c = oc[v] - ((acc && int'(in_vc) == v) ? 1 : 0) + (credit_ret[v] ? 1 : 0);
            if (c > MAXC) begin
                c = MAXC;
                m_cerr[v] = 1'b1;
            end
            m_cred[v] = c;
        end
        starving = in_valid && vc_ok && (vc_ok ? oc[int'(in_vc)] == 0 : 1'b0);
        if (acc || !in_valid) m_starve = 0;
        else if (starving && m_starve < LIM) m_starve = m_starve + 1;
        if (err_clr) m_stall = 1'b0;
        if (starving && m_starve >= LIM) m_stall = 1'b1;
        if (acc) begin
            m_ov  = 1'b1;
            m_ovc = int'(in_vc);
            m_od  = in_data;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic check_all(input string p);
        logic [VC_NUM*CW-1:0] ecc;
        logic [VC_NUM-1:0]    eerr;
        for (int v = 0; v < VC_NUM; v++) begin
            ecc[v*CW +: CW] = CW'(m_cred[v]);
            eerr[v]         = m_cerr[v];
        end
        chk({p, ".credit_cnt"}, 64'(credit_cnt), 64'(ecc));
        chk({p, ".credit_err"}, 64'(credit_err), 64'(eerr));
        chk({p, ".stall_err"}, 64'(stall_err), 64'(m_stall));
        chk({p, ".in_ready"}, 64'(in_ready), 64'(model_ready()));
        chk({p, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        chk({p, ".out_vc"}, 64'(out_vc), 64'(m_ovc));
        chk({p, ".out_data"}, out_data, m_od);
        chk({p, ".pause_req"}, 64'(pause_req_o), 64'(m_phase == 1));
        chk({p, ".pause_active"}, 64'(pause_active), 64'(m_phase == 2));
    endtask

    // Compare at the falling edge, then advance model and DUT across one rising edge.
    task automatic tick(output bit acc);
        @(negedge clk);
        check_all("tick");
        acc = in_valid && model_ready();
        @(posedge clk);
        model_update(acc);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        credit_ret = '0;
        err_clr    = 1'b0;
        rst_n      = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_flit(input int vc, input logic [63:0] d);
        bit a = 1'b0;
        in_valid = 1'b1;
        in_vc    = VC_W'(vc);
        in_data  = d;
        for (int k = 0; k < 64 && !a; k++) tick(a);
        chk("send_accepted", 64'(a), 64'd1);
        in_valid = 1'b0;
    endtask

    function automatic int cred_of(input int v);
        logic [VC_NUM*CW-1:0] cc;
        cc = credit_cnt;
        return int'(cc[v*CW +: CW]);
    endfunction

    initial begin
        bit a;
        int n;
        #3;
        do_reset();

        // VC0 streams 16 flits, then runs dry
        for (int i = 0; i < 16; i++) begin
            send_flit(0, 64'hA000 + 64'(i));
            chk("stream_data", out_data, 64'hA000 + 64'(i));
        end
        chk("vc0_drained", 64'(cred_of(0)), 64'd0);
        in_valid = 1'b1; in_vc = '0; in_data = 64'hA010;
        tick(a);
        chk("vc0_17th_ready", 64'(in_ready), 64'd0);
        chk("vc0_17th_held", 64'(a), 64'd0);
        in_valid = 1'b0;

        // Overflow on idle VC2, then clear
        do_reset();
        credit_ret = 4'b0100;
        tick(a);
        credit_ret = '0;
        chk("ovf_cnt2", 64'(cred_of(2)), 64'd16);
        chk("ovf_err", 64'(credit_err), 64'h4);
        err_clr = 1'b1;
        tick(a);
        err_clr = 1'b0;
        chk("ovf_clr", 64'(credit_err), 64'h0);

        // Simultaneous consume and return on VC1 at 5 credits
        do_reset();
        for (int i = 0; i < 11; i++) send_flit(1, 64'hB000 + 64'(i));
        chk("vc1_at5", 64'(cred_of(1)), 64'd5);
        in_valid = 1'b1; in_vc = 2'd1; in_data = 64'hB0FF; credit_ret = 4'b0010;
        tick(a);
        in_valid = 1'b0; credit_ret = '0;
        chk("vc1_same_cycle_acc", 64'(a), 64'd1);
        chk("vc1_same_cycle_cnt", 64'(cred_of(1)), 64'd5);

        // Starvation on VC3
        do_reset();
        for (int i = 0; i < 16; i++) send_flit(3, 64'hC000 + 64'(i));
        in_valid = 1'b1; in_vc = 2'd3; in_data = 64'hC0FF;
        repeat (254) tick(a);
        chk("stall_at_254", 64'(stall_err), 64'd0);
        tick(a);
        chk("stall_at_255", 64'(stall_err), 64'd1);
        err_clr = 1'b1;
        tick(a);
        chk("stall_clr_loses", 64'(stall_err), 64'd1);
        in_valid = 1'b0;
        tick(a);
        err_clr = 1'b0;
        chk("stall_cleared", 64'(stall_err), 64'd0);

        // Backpressure holds the flit; reset discards it
        do_reset();
        out_ready = 1'b0;
        send_flit(2, 64'hD00D);
        in_valid = 1'b1; in_vc = 2'd0; in_data = 64'hD1D1;
        repeat (3) begin
            tick(a);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_data", out_data, 64'hD00D);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("bp_rst_valid", 64'(out_valid), 64'd0);
        for (int v = 0; v < VC_NUM; v++) chk("bp_rst_cnt", 64'(cred_of(v)), 64'd16);
        check_all("bp_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

`ifdef NOC_FC_PAUSE_EN
        // Pause window after VC0 falls to the low watermark
        do_reset();
        pause_quanta = 16'd10;
        for (int i = 0; i < 14; i++) send_flit(0, 64'hE000 + 64'(i));
        for (int k = 0; k < 20 && !pause_req_o; k++) tick(a);
        chk("pause_req_seen", 64'(pause_req_o), 64'd1);
        in_valid = 1'b1; in_vc = 2'd1; in_data = 64'hE0FF;
        n = 0;
        repeat (10) begin
            tick(a);
            if (pause_active) n++;
            chk("pause_ready", 64'(in_ready), 64'd0);
            chk("pause_req_pulse", 64'(pause_req_o), 64'd0);
        end
        chk("pause_len", 64'(n), 64'd10);
        tick(a);
        chk("pause_end", 64'(pause_active), 64'd0);
        in_valid = 1'b0;
`endif

        // Randomized traffic against the model
        do_reset();
        repeat (3000) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_vc        = VC_W'($urandom_range(0, VC_NUM - 1));
            in_data      = {$urandom, $urandom};
            out_ready    = ($urandom_range(0, 3) != 0);
            for (int v = 0; v < VC_NUM; v++) credit_ret[v] = ($urandom_range(0, 4) == 0);
            err_clr      = ($urandom_range(0, 49) == 0);
            pause_quanta = 16'($urandom_range(0, 6));
            tick(a);
        end
        in_valid = 1'b0; credit_ret = '0; err_clr = 1'b0;
        tick(a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
